// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// data_mem_responder_if : CPU load/store request/response bundle
// Revision 1.0
// ---------------------------------------------------------------------------
interface data_mem_responder_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  MemRead;
  logic                  MemWrite;
  logic [ADDR_WIDTH-1:0] Address;
  logic [ADDR_WIDTH-1:0] WriteData;
  logic                  mode;
  logic                  Ready;
  logic                  RespValid;
  logic [ADDR_WIDTH-1:0] ReadData;
  logic                  Error;

  modport master (
    output MemRead, MemWrite, Address, WriteData, mode,
    input  Ready, RespValid, ReadData, Error
  );

  modport slave (
    input  MemRead, MemWrite, Address, WriteData, mode,
    output Ready, RespValid, ReadData, Error
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// data_mem_responder : fixed-latency data memory target, one request at a time
// Revision 1.0
// ---------------------------------------------------------------------------
module data_mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 3
) (
  input  wire logic clk,
  input  wire logic rst,
  data_mem_responder_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [IDX_W-1:0]      idx_q;
  logic [1:0]            lane_q;
  logic [31:0]           wdata_q;
  logic                  mode_q;
  logic                  write_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] rdata;
  logic                  err_out;

  // Not cleared by reset: contents survive a mid-flight reset.
  logic [31:0] mem [DEPTH];

  logic        req;
  logic        req_err;
  logic        execute;
  logic        do_write;
  logic [31:0] word;
  logic [7:0]  lane_byte;
  logic [31:0] load_val;

  assign req     = bus.MemRead | bus.MemWrite;
  assign req_err = (bus.MemRead & bus.MemWrite)
                 | (~bus.mode & (bus.Address[1:0] != 2'b00))
                 | (bus.Address >= ADDR_WIDTH'(DEPTH * 4));

  assign execute  = (state == BUSY) && (cnt == 4'd0);
  assign do_write = ~rst & execute & write_q & ~err_q;

  assign word = mem[idx_q];

  always_comb begin
    lane_byte = word[7:0];
    case (lane_q)
      2'd1:    lane_byte = word[15:8];
      2'd2:    lane_byte = word[23:16];
      2'd3:    lane_byte = word[31:24];
      default: lane_byte = word[7:0];
    endcase
  end

  assign load_val = mode_q ? {24'd0, lane_byte} : word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      idx_q   <= '0;
      lane_q  <= 2'd0;
      wdata_q <= 32'd0;
      mode_q  <= 1'b0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      rdata   <= '0;
      err_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            idx_q   <= bus.Address[IDX_W+1:2];
            lane_q  <= bus.Address[1:0];
            wdata_q <= bus.WriteData[31:0];
            mode_q  <= bus.mode;
            write_q <= bus.MemWrite;
            err_q   <= req_err;
            cnt     <= 4'(LATENCY - 1);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state   <= RESP;
            rdata   <= (err_q | write_q) ? '0 : ADDR_WIDTH'(load_val);
            err_out <= err_q;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state   <= IDLE;
          rdata   <= '0;
          err_out <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      if (mode_q) begin
        mem[idx_q][{lane_q, 3'b000} +: 8] <= wdata_q[7:0];
      end else begin
        mem[idx_q] <= wdata_q;
      end
    end
  end

  assign bus.Ready     = (state == IDLE);
  assign bus.RespValid = (state == RESP);
  assign bus.ReadData  = rdata;
  assign bus.Error     = err_out;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_data_mem_responder : directed bench with an expected-response queue
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_data_mem_responder;
  localparam int AW  = 32;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_responder_if #(.ADDR_WIDTH(AW)) bus3 ();
  data_mem_responder_if #(.ADDR_WIDTH(AW)) bus1 ();

  data_mem_responder #(.ADDR_WIDTH(AW), .DEPTH(256), .LATENCY(LAT)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  data_mem_responder #(.ADDR_WIDTH(AW), .DEPTH(256), .LATENCY(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Issue one request on the LATENCY=3 target and score its single response.
  task automatic do_req(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wd, input logic md,
                        input logic [31:0] exp_d, input logic exp_e);
    int   k;
    exp_t e;
    k = 0;
    while (bus3.Ready !== 1'b1 && k < 50) begin
      @(posedge clk); @(negedge clk); k++;
    end
    check({tag, "_ready"}, 32'(bus3.Ready), 32'd1);
    bus3.MemRead   = rd;
    bus3.MemWrite  = wr;
    bus3.Address   = addr;
    bus3.WriteData = wd;
    bus3.mode      = md;
    sb.push_back('{data: exp_d, err: exp_e});
    @(posedge clk); @(negedge clk);
    bus3.MemRead  = 1'b0;
    bus3.MemWrite = 1'b0;
    check({tag, "_busy"}, 32'(bus3.Ready), 32'd0);
    k = 0;
    while (bus3.RespValid !== 1'b1 && k < 50) begin
      @(posedge clk); @(negedge clk); k++;
    end
    check({tag, "_valid"}, 32'(bus3.RespValid), 32'd1);
    check({tag, "_lat"}, 32'(k), 32'(LAT));
    e = sb.pop_front();
    check({tag, "_data"}, bus3.ReadData, e.data);
    check({tag, "_err"}, 32'(bus3.Error), 32'(e.err));
    @(posedge clk); @(negedge clk);
    check({tag, "_pulse"}, 32'(bus3.RespValid), 32'd0);
    check({tag, "_rdclr"}, bus3.ReadData, 32'd0);
  endtask

  initial begin
    int acc;
    int rsp;
    bus3.MemRead = 1'b0; bus3.MemWrite = 1'b0; bus3.Address = '0; bus3.WriteData = '0; bus3.mode = 1'b0;
    bus1.MemRead = 1'b0; bus1.MemWrite = 1'b0; bus1.Address = '0; bus1.WriteData = '0; bus1.mode = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", 32'(bus3.Ready), 32'd1);
    check("rst_valid", 32'(bus3.RespValid), 32'd0);
    check("rst_rdata", bus3.ReadData, 32'd0);
    check("rst_err", 32'(bus3.Error), 32'd0);
    @(posedge clk); @(negedge clk);
    check("idle_ready", 32'(bus3.Ready), 32'd1);
    check("idle_valid", 32'(bus3.RespValid), 32'd0);

    do_req("st_word",  1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0);
    do_req("ld_word",  1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 1'b0);
    do_req("st_w20",   1'b0, 1'b1, 32'h20,  32'h11223344, 1'b0, 32'h0,        1'b0);
    do_req("st_byte",  1'b0, 1'b1, 32'h22,  32'hFFFFFFAA, 1'b1, 32'h0,        1'b0);
    do_req("ld_w20",   1'b1, 1'b0, 32'h20,  32'h0,        1'b0, 32'h11AA3344, 1'b0);
    do_req("ld_b23",   1'b1, 1'b0, 32'h23,  32'h0,        1'b1, 32'h00000011, 1'b0);
    do_req("ld_b20",   1'b1, 1'b0, 32'h20,  32'h0,        1'b1, 32'h00000044, 1'b0);
    do_req("st_last",  1'b0, 1'b1, 32'h3FC, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0);
    do_req("ld_last",  1'b1, 1'b0, 32'h3FC, 32'h0,        1'b0, 32'hCAFEF00D, 1'b0);
    do_req("st_zero",  1'b0, 1'b1, 32'h0,   32'h0BADF00D, 1'b0, 32'h0,        1'b0);

    do_req("err_mis",  1'b1, 1'b0, 32'h21,  32'h0,        1'b0, 32'h0,        1'b1);
    do_req("err_both", 1'b1, 1'b1, 32'h20,  32'h0,        1'b0, 32'h0,        1'b1);
    do_req("err_oob",  1'b1, 1'b0, 32'h400, 32'h0,        1'b0, 32'h0,        1'b1);
    do_req("err_oobw", 1'b0, 1'b1, 32'h400, 32'h12345678, 1'b0, 32'h0,        1'b1);
    do_req("err_oobb", 1'b0, 1'b1, 32'h401, 32'h000000EE, 1'b1, 32'h0,        1'b1);
    do_req("ld_after", 1'b1, 1'b0, 32'h20,  32'h0,        1'b0, 32'h11AA3344, 1'b0);
    do_req("ld_zero",  1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0BADF00D, 1'b0);

    // Back-to-back reads held high on the LATENCY=1 target: IDLE, BUSY, RESP repeating.
    acc = 0;
    rsp = 0;
    bus1.MemRead = 1'b1;
    bus1.Address = 32'h10;
    for (int i = 0; i < 12; i++) begin
      check("b2b_ready", 32'(bus1.Ready), 32'((i % 3) == 0));
      check("b2b_valid", 32'(bus1.RespValid), 32'((i % 3) == 2));
      if (bus1.Ready === 1'b1) acc++;
      if (bus1.RespValid === 1'b1) begin
        rsp++;
        check("b2b_err", 32'(bus1.Error), 32'd0);
      end
      @(posedge clk); @(negedge clk);
    end
    bus1.MemRead = 1'b0;
    check("b2b_acc", 32'(acc), 32'd4);
    check("b2b_rsp", 32'(rsp), 32'd4);

    do_req("st_w30",   1'b0, 1'b1, 32'h30,  32'h12345678, 1'b0, 32'h0,        1'b0);

    // Store of 0x55 to 0x30 aborted by reset while BUSY.
    bus3.MemWrite  = 1'b1;
    bus3.Address   = 32'h30;
    bus3.WriteData = 32'h55;
    bus3.mode      = 1'b0;
    @(posedge clk); @(negedge clk);
    bus3.MemWrite = 1'b0;
    check("mid_busy", 32'(bus3.Ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("mid_ready", 32'(bus3.Ready), 32'd1);
    rsp = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus3.RespValid === 1'b1) rsp++;
      @(posedge clk); @(negedge clk);
    end
    check("mid_novalid", 32'(rsp), 32'd0);
    do_req("ld_w30",   1'b1, 1'b0, 32'h30,  32'h0,        1'b0, 32'h12345678, 1'b0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout passed=%0d total=%0d", passed, total);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
